// File: rtl/ras_stack_ctrl_pkg.sv
// Shared types and default sizes for the return-address-stack controller.
// The optional RAS_CTRL_STATS_EN build adds overflow/underflow counters.
package ras_pkg;

   // Controller sequencing: IDLE accepts pops; REFILL captures the BRAM
   // read that restores the registered top-of-stack copy.
   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } ras_ctrl_state_e;

   localparam int RAS_DEPTH = 1024;
   localparam int RAS_WIDTH = 32;

endpackage : ras_pkg

// File: rtl/ras_stack_ctrl_if.sv
// Front-end side of the RAS controller: push (call), pop (return) and
// checkpoint restore, plus the pointer/count taps used for checkpointing.
interface ras_stack_ctrl_if
   import ras_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH,
   parameter int WIDTH = RAS_WIDTH
);
   localparam int ADDR = $clog2(DEPTH);

   logic             push_valid;
   logic [WIDTH-1:0] push_addr;
   logic             push_ready;
   logic             pop_valid;
   logic             pop_ready;
   logic [WIDTH-1:0] pop_addr;
   logic             pop_empty;
   logic             restore_valid;
   logic [ADDR-1:0]  restore_sp;
   logic [ADDR:0]    restore_count;
   logic [ADDR-1:0]  sp_o;
   logic [ADDR:0]    count_o;

   // Branch-prediction front end
   modport master (
      output push_valid, push_addr, pop_valid,
             restore_valid, restore_sp, restore_count,
      input  push_ready, pop_ready, pop_addr, pop_empty, sp_o, count_o
   );

   // Stack controller
   modport slave (
      input  push_valid, push_addr, pop_valid,
             restore_valid, restore_sp, restore_count,
      output push_ready, pop_ready, pop_addr, pop_empty, sp_o, count_o
   );

endinterface : ras_stack_ctrl_if

// File: rtl/ras_bram.sv
// Dual-port return-address-stack RAM, one write and one read per port,
// registered read data (1-cycle latency, read-before-write).
// OFS rotates every address by a constant; INCR is added to written data.
// With OFS=0, INCR=0 it is a plain RAM.
module ras_bram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 32,
   parameter int OFS   = 0,
   parameter int INCR  = 0
) (
   input  logic                     clk,
   input  logic                     rea,
   input  logic [$clog2(DEPTH)-1:0] raddra,
   input  logic                     wea,
   input  logic [$clog2(DEPTH)-1:0] waddra,
   input  logic [WIDTH-1:0]         wia,
   output logic [WIDTH-1:0]         doa,
   input  logic                     reb,
   input  logic [$clog2(DEPTH)-1:0] raddrb,
   input  logic                     web,
   input  logic [$clog2(DEPTH)-1:0] waddrb,
   input  logic [WIDTH-1:0]         wib,
   output logic [WIDTH-1:0]         dob
);
   localparam int ADDR = $clog2(DEPTH);
   localparam logic [ADDR-1:0]  OFS_A  = OFS[ADDR-1:0];
   localparam logic [WIDTH-1:0] INCR_D = INCR[WIDTH-1:0];

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage writes and registered reads on both ports
   always_ff @(posedge clk) begin
      if (rea) doa <= mem[raddra + OFS_A];
      if (reb) dob <= mem[raddrb + OFS_A];
      if (wea) mem[waddra + OFS_A] <= wia + INCR_D;
      if (web) mem[waddrb + OFS_A] <= wib + INCR_D;
   end

endmodule : ras_bram

// File: rtl/ras_stack_ctrl_stats.sv
// Saturating overflow/underflow event counters for the RAS controller.
// Instantiated only when RAS_CTRL_STATS_EN is defined.
module ras_ctrl_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ovf_inc,
   input  logic        unf_inc,
   output logic [31:0] ovf_cnt,
   output logic [31:0] unf_cnt
);

   logic [31:0] ovf_cnt_q, ovf_cnt_d;
   logic [31:0] unf_cnt_q, unf_cnt_d;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Next counter values: bump on each event, holding at all-ones
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      unf_cnt_d = unf_cnt_q;
      if (ovf_inc) ovf_cnt_d = sat_inc32(ovf_cnt_q);
      if (unf_inc) unf_cnt_d = sat_inc32(unf_cnt_q);
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
         unf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
         unf_cnt_q <= unf_cnt_d;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
   assign unf_cnt = unf_cnt_q;

endmodule : ras_ctrl_stats

// File: rtl/ras_stack_ctrl.sv
// Return-address-stack sequencer: turns push/pop/restore requests into
// ras_bram accesses, keeping sp, occupancy and a registered TOS copy so a
// pop answers in its handshake cycle. Port A only writes, port B only reads.
// Optional macro RAS_CTRL_STATS_EN adds ovf_cnt/unf_cnt outputs.
module ras_stack_ctrl
   import ras_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH,
   parameter int WIDTH = RAS_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ras_stack_ctrl_if.slave          bus,
   output logic                     bram_rea,
   output logic                     bram_wea,
   output logic                     bram_reb,
   output logic                     bram_web,
   output logic [$clog2(DEPTH)-1:0] bram_raddra,
   output logic [$clog2(DEPTH)-1:0] bram_waddra,
   output logic [$clog2(DEPTH)-1:0] bram_raddrb,
   output logic [$clog2(DEPTH)-1:0] bram_waddrb,
   output logic [WIDTH-1:0]         bram_wia,
   output logic [WIDTH-1:0]         bram_wib,
   input  logic [WIDTH-1:0]         bram_doa,
   input  logic [WIDTH-1:0]         bram_dob
`ifdef RAS_CTRL_STATS_EN
   ,
   output logic [31:0]              ovf_cnt,
   output logic [31:0]              unf_cnt
`endif
);
   localparam int ADDR = $clog2(DEPTH);
   localparam logic [ADDR:0] FULL = DEPTH[ADDR:0];

   ras_ctrl_state_e  state_q, state_d;
   logic [ADDR-1:0]  sp_q, sp_d;
   logic [ADDR:0]    count_q, count_d;
   logic [WIDTH-1:0] tos_q, tos_d;

   logic push_fire;
   logic pop_fire;
   logic pop_take;
   logic unused_doa;

   // Port A is write-only, so its read data is never consumed.
   assign unused_doa = ^bram_doa;

   function automatic logic [ADDR:0] count_sat_inc(input logic [ADDR:0] c);
      return (c == FULL) ? c : c + 1'b1;
   endfunction

   assign bus.push_ready = !bus.restore_valid;
   assign bus.pop_ready  = !bus.restore_valid && (state_q == IDLE);
   assign bus.pop_addr   = tos_q;
   assign bus.pop_empty  = (count_q == '0);
   assign bus.sp_o       = sp_q;
   assign bus.count_o    = count_q;

   assign push_fire = bus.push_valid && bus.push_ready;
   assign pop_fire  = bus.pop_valid && bus.pop_ready;
   assign pop_take  = pop_fire && !bus.pop_empty;

   // Next-state, pointer/count/TOS update and BRAM port drive
   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      count_d     = count_q;
      tos_d       = tos_q;
      bram_rea    = 1'b0;
      bram_raddra = '0;
      bram_wea    = 1'b0;
      bram_waddra = '0;
      bram_wia    = '0;
      bram_reb    = 1'b0;
      bram_raddrb = '0;
      bram_web    = 1'b0;
      bram_waddrb = '0;
      bram_wib    = '0;

      if (bus.restore_valid) begin
         // Checkpoint wins over everything, including a pending refill.
         sp_d    = bus.restore_sp;
         count_d = bus.restore_count;
         state_d = IDLE;
         if (bus.restore_count != '0) begin
            bram_reb    = 1'b1;
            bram_raddrb = bus.restore_sp - 1'b1;
            state_d     = REFILL;
         end
      end else begin
         // Capture the read issued last cycle; a push below overrides it.
         if (state_q == REFILL) begin
            tos_d   = bram_dob;
            state_d = IDLE;
         end

         if (push_fire && pop_take) begin
            // Call and return together: replace the top entry in place.
            bram_wea    = 1'b1;
            bram_waddra = sp_q - 1'b1;
            bram_wia    = bus.push_addr;
            tos_d       = bus.push_addr;
         end else if (push_fire) begin
            // Full stack wraps and overwrites the oldest entry.
            bram_wea    = 1'b1;
            bram_waddra = sp_q;
            bram_wia    = bus.push_addr;
            tos_d       = bus.push_addr;
            sp_d        = sp_q + 1'b1;
            count_d     = count_sat_inc(count_q);
            state_d     = IDLE;
         end else if (pop_take) begin
            sp_d    = sp_q - 1'b1;
            count_d = count_q - 1'b1;
            if (count_q > 1) begin
               bram_reb    = 1'b1;
               bram_raddrb = sp_q - ADDR'(2);
               state_d     = REFILL;
            end
         end
      end
   end

   // Control and TOS registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sp_q    <= '0;
         count_q <= '0;
         tos_q   <= '0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         count_q <= count_d;
         tos_q   <= tos_d;
      end
   end

`ifdef RAS_CTRL_STATS_EN
   ras_ctrl_stats u_stats (
      .clk     (clk),
      .rst_n   (rst_n),
      .ovf_inc (push_fire && (count_q == FULL)),
      .unf_inc (pop_fire && bus.pop_empty),
      .ovf_cnt (ovf_cnt),
      .unf_cnt (unf_cnt)
   );
`endif

endmodule : ras_stack_ctrl
